regfile_32x64: RTL

- Architectural register file for the single-cycle/pipelined LEGv8 datapath.
- Sits directly upstream of the operand-select 2:1 mux stage: ReadData2 feeds the ALUSrc mux, and ReadData1 feeds the ALU A input.
- 32 registers by 64 bits, two combinational read ports, one synchronous write port.
- X31 (XZR) always reads zero.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_32x64_reg_en.sv | 34 +++
 rtl/regfile_32x64.sv | 71 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants and types for the LEGv8 architectural register file.
package regfile_pkg;

  localparam int unsigned WIDTH    = 64;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned ZERO_REG = 31;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [WIDTH-1:0]  reg_data_t;

endpackage

// File: rtl/regfile_32x64_reg_en.sv
// reg_en: WIDTH-bit enabled register.
// Each bit is a 2:1 feedback mux (select = en) into an async-reset DFF.
//   clk   : rising-edge clock
//   reset : asynchronous, active-high clear
//   en    : load enable
//   d     : data to load
//   q     : stored value
module reg_en
  import regfile_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] nxt;

  // Per-bit hold/load mux.
  for (genvar b = 0; b < int'(WIDTH); b++) begin : g_bit
    assign nxt[b] = en ? d[b] : q[b];
  end

  // Storage flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= '0;
    end else begin
      q <= nxt;
    end
  end

endmodule

// File: rtl/regfile_32x64.sv
// regfile_32x64: 32 x 64-bit LEGv8 register file.
// Two combinational read ports, one synchronous write port, X31 reads zero.
//   clk           : rising-edge clock
//   reset         : asynchronous, active-high; clears all registers
//   RegWrite      : write enable
//   WriteRegister : destination index
//   WriteData     : data to write
//   ReadRegister1 : read port 1 index (ReadData1 feeds ALU A)
//   ReadRegister2 : read port 2 index (ReadData2 feeds ALUSrc mux)
//   ReadData1/2   : combinational read data, no write bypass
module regfile_32x64
  import regfile_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [ADDR_W-1:0] WriteRegister,
  input  logic [WIDTH-1:0]  WriteData,
  input  logic [ADDR_W-1:0] ReadRegister1,
  input  logic [ADDR_W-1:0] ReadRegister2,
  output logic [WIDTH-1:0]  ReadData1,
  output logic [WIDTH-1:0]  ReadData2
);

  // Mux tree nodes: 32 leaves, then 16, 8, 4, 2, 1 (root at the last index).
  localparam int unsigned NODES = 2 * NUM_REGS - 1;

  reg_data_t q    [NUM_REGS];
  reg_data_t tree [2][NODES];
  reg_addr_t raddr[2];

  assign raddr[0] = ReadRegister1;
  assign raddr[1] = ReadRegister2;

  // Decoder + storage; the zero register has no flops, only a constant leaf.
  for (genvar i = 0; i < int'(NUM_REGS); i++) begin : g_reg
    if (i == int'(ZERO_REG)) begin : g_zero
      assign q[i] = '0;
    end else begin : g_store
      logic en;
      // Gating by RegWrite keeps an unknown address harmless when idle.
      assign en = RegWrite & (WriteRegister == ADDR_W'(i));
      reg_en u_reg (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .d     (WriteData),
        .q     (q[i])
      );
    end
  end

  // Read mux trees: 5 levels of 2:1 muxes, address bits consumed LSB-first.
  for (genvar p = 0; p < 2; p++) begin : g_port
    for (genvar n = 0; n < int'(NUM_REGS); n++) begin : g_leaf
      assign tree[p][n] = q[n];
    end
    for (genvar l = 0; l < int'(ADDR_W); l++) begin : g_lvl
      localparam int unsigned BASE = 2 * NUM_REGS - ((2 * NUM_REGS) >> l);
      localparam int unsigned NEXT = 2 * NUM_REGS - ((2 * NUM_REGS) >> (l + 1));
      for (genvar n = 0; n < int'(NUM_REGS >> (l + 1)); n++) begin : g_mux
        assign tree[p][NEXT + n] = raddr[p][l] ? tree[p][BASE + 2 * n + 1]
                                               : tree[p][BASE + 2 * n];
      end
    end
  end

  assign ReadData1 = tree[0][NODES - 1];
  assign ReadData2 = tree[1][NODES - 1];

endmodule
